raster_scan_ctrl: RTL and testbench



---
 rtl/raster_scan_ctrl_if.sv | 60 ++++++
 rtl/raster_scan_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_raster_scan_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scan_ctrl_if.sv
// Signal bundle between triangle setup, the barycentric rasterizer and the
// depth/shade stage. The controller takes the slave view; the environment takes the master view.
interface raster_scan_ctrl_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [9:0]  tri_ax;
  logic [9:0]  tri_ay;
  logic [9:0]  tri_bx;
  logic [9:0]  tri_by;
  logic [9:0]  tri_cx;
  logic [9:0]  tri_cy;
  logic [6:0]  tri_bz;
  logic [6:0]  tri_cz;

  logic [9:0]  ras_ax;
  logic [9:0]  ras_ay;
  logic [9:0]  ras_bx;
  logic [9:0]  ras_by;
  logic [9:0]  ras_cx;
  logic [9:0]  ras_cy;
  logic [6:0]  ras_bz;
  logic [6:0]  ras_cz;
  logic [9:0]  ras_x;
  logic [9:0]  ras_y;
  logic        ras_visible;
  logic [19:0] ras_uw;
  logic [19:0] ras_vw;
  logic [19:0] ras_ww;
  logic [19:0] ras_aw;

  logic        frag_valid;
  logic        frag_ready;
  logic [9:0]  frag_x;
  logic [9:0]  frag_y;
  logic [19:0] frag_uw;
  logic [19:0] frag_vw;
  logic [19:0] frag_ww;
  logic [19:0] frag_aw;
  logic        done;

  modport slave (
    input  tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_bz, tri_cz,
    output tri_ready,
    output ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_bz, ras_cz, ras_x, ras_y,
    input  ras_visible, ras_uw, ras_vw, ras_ww, ras_aw,
    output frag_valid, frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw,
    input  frag_ready,
    output done
  );

  modport master (
    output tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_bz, tri_cz,
    input  tri_ready,
    input  ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_bz, ras_cz, ras_x, ras_y,
    output ras_visible, ras_uw, ras_vw, ras_ww, ras_aw,
    input  frag_valid, frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw,
    output frag_ready,
    input  done
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Walks the screen-clipped bounding box of one triangle pixel by pixel, feeding the
// rasterizer and forwarding covered pixels through a backpressured fragment register.
module raster_scan_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic               clk,
  input logic               rst_n,
  raster_scan_ctrl_if.slave bus
);

  localparam logic [9:0] X_LAST = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LAST = 10'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [9:0]  r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  logic [6:0]  r_bz, r_cz;
  logic [9:0]  r_x, r_y;
  logic [9:0]  r_xmin, r_xmax, r_ymin, r_ymax;

  logic        r_frag_valid;
  logic [9:0]  r_frag_x, r_frag_y;
  logic [19:0] r_frag_uw, r_frag_vw, r_frag_ww, r_frag_aw;

  logic [9:0]  w_xmin, w_xmax_raw, w_xmax;
  logic [9:0]  w_ymin, w_ymax_raw, w_ymax;
  logic        w_empty;
  logic        w_accept;
  logic        w_can_accept;
  logic        w_advance;
  logic        w_frag_load;
  logic        w_row_end;
  logic        w_last_pixel;
  logic        w_done;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Only the max side is clamped; a min beyond the screen edge shows up as an empty box.
  assign w_xmin     = min3(r_ax, r_bx, r_cx);
  assign w_xmax_raw = max3(r_ax, r_bx, r_cx);
  assign w_xmax     = (w_xmax_raw > X_LAST) ? X_LAST : w_xmax_raw;
  assign w_ymin     = min3(r_ay, r_by, r_cy);
  assign w_ymax_raw = max3(r_ay, r_by, r_cy);
  assign w_ymax     = (w_ymax_raw > Y_LAST) ? Y_LAST : w_ymax_raw;
  assign w_empty    = (w_xmin > w_xmax) || (w_ymin > w_ymax);

  assign w_accept     = (r_state == IDLE) && bus.tri_valid;
  assign w_can_accept = !r_frag_valid || bus.frag_ready;
  assign w_row_end    = (r_x == r_xmax);
  assign w_last_pixel = w_row_end && (r_y == r_ymax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_advance   = 1'b0;
    w_frag_load = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = SETUP;
        end
      end
      SETUP: begin
        w_next = w_empty ? DRAIN : SCAN;
      end
      SCAN: begin
        // A covered pixel waits only while the fragment register cannot take it.
        if (!(bus.ras_visible && !w_can_accept)) begin
          w_advance   = 1'b1;
          w_frag_load = bus.ras_visible;
          if (w_last_pixel) begin
            w_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_frag_valid) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax <= '0;
      r_ay <= '0;
      r_bx <= '0;
      r_by <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_bz <= '0;
      r_cz <= '0;
    end else if (w_accept) begin
      r_ax <= bus.tri_ax;
      r_ay <= bus.tri_ay;
      r_bx <= bus.tri_bx;
      r_by <= bus.tri_by;
      r_cx <= bus.tri_cx;
      r_cy <= bus.tri_cy;
      r_bz <= bus.tri_bz;
      r_cz <= bus.tri_cz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (r_state == SETUP) begin
      r_xmin <= w_xmin;
      r_xmax <= w_xmax;
      r_ymin <= w_ymin;
      r_ymax <= w_ymax;
    end
  end

  // The scan position stays on the final pixel once the box is exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if ((r_state == SETUP) && !w_empty) begin
      r_x <= w_xmin;
      r_y <= w_ymin;
    end else if (w_advance && !w_last_pixel) begin
      if (w_row_end) begin
        r_x <= r_xmin;
        r_y <= r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frag_valid <= 1'b0;
      r_frag_x     <= '0;
      r_frag_y     <= '0;
      r_frag_uw    <= '0;
      r_frag_vw    <= '0;
      r_frag_ww    <= '0;
      r_frag_aw    <= '0;
    end else if (w_frag_load) begin
      r_frag_valid <= 1'b1;
      r_frag_x     <= r_x;
      r_frag_y     <= r_y;
      r_frag_uw    <= bus.ras_uw;
      r_frag_vw    <= bus.ras_vw;
      r_frag_ww    <= bus.ras_ww;
      r_frag_aw    <= bus.ras_aw;
    end else if (bus.frag_ready) begin
      r_frag_valid <= 1'b0;
    end
  end

  assign bus.tri_ready  = (r_state == IDLE);
  assign bus.ras_ax     = r_ax;
  assign bus.ras_ay     = r_ay;
  assign bus.ras_bx     = r_bx;
  assign bus.ras_by     = r_by;
  assign bus.ras_cx     = r_cx;
  assign bus.ras_cy     = r_cy;
  assign bus.ras_bz     = r_bz;
  assign bus.ras_cz     = r_cz;
  assign bus.ras_x      = r_x;
  assign bus.ras_y      = r_y;
  assign bus.frag_valid = r_frag_valid;
  assign bus.frag_x     = r_frag_x;
  assign bus.frag_y     = r_frag_y;
  assign bus.frag_uw    = r_frag_uw;
  assign bus.frag_vw    = r_frag_vw;
  assign bus.frag_ww    = r_frag_ww;
  assign bus.frag_aw    = r_frag_aw;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed bench for raster_scan_ctrl with a behavioural edge-function rasterizer
// standing in for the real one and a full-screen golden fragment list per triangle.
module tb_raster_scan_ctrl;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [19:0] uw;
    logic [19:0] vw;
    logic [19:0] ww;
    logic [19:0] aw;
  } frag_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  frag_t gold[$];
  frag_t got[$];

  logic [80:0] rasOut;

  raster_scan_ctrl_if bus();

  raster_scan_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int edgeFn(input int ax, input int ay, input int bx, input int by,
                                input int px, input int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic [19:0] mag20(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return a[19:0];
  endfunction

  // Packed result: {visible, uw, vw, ww, aw}; edges inclusive, zero area never covers.
  function automatic logic [80:0] raster(input int ax, input int ay, input int bx, input int by,
                                         input int cx, input int cy, input int px, input int py);
    int area, w0, w1, w2;
    logic vis;
    area = edgeFn(ax, ay, bx, by, cx, cy);
    w0   = edgeFn(bx, by, cx, cy, px, py);
    w1   = edgeFn(cx, cy, ax, ay, px, py);
    w2   = edgeFn(ax, ay, bx, by, px, py);
    if (area > 0)      vis = (w0 >= 0) && (w1 >= 0) && (w2 >= 0);
    else if (area < 0) vis = (w0 <= 0) && (w1 <= 0) && (w2 <= 0);
    else               vis = 1'b0;
    return {vis, mag20(w0), mag20(w1), mag20(w2), mag20(area)};
  endfunction

  always_comb begin
    rasOut = raster(int'(bus.ras_ax), int'(bus.ras_ay), int'(bus.ras_bx), int'(bus.ras_by),
                    int'(bus.ras_cx), int'(bus.ras_cy), int'(bus.ras_x), int'(bus.ras_y));
    bus.ras_visible = rasOut[80];
    bus.ras_uw      = rasOut[79:60];
    bus.ras_vw      = rasOut[59:40];
    bus.ras_ww      = rasOut[39:20];
    bus.ras_aw      = rasOut[19:0];
  end

  task automatic build_gold(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
    logic [80:0] r;
    gold.delete();
    for (int y = 0; y < 480; y++) begin
      for (int x = 0; x < 640; x++) begin
        r = raster(ax, ay, bx, by, cx, cy, x, y);
        if (r[80]) gold.push_back(frag_t'({10'(x), 10'(y), r[79:0]}));
      end
    end
  endtask

  // Offers one triangle and follows it cycle by cycle; k counts cycles after acceptance.
  // mode 0 keeps frag_ready high, mode 1 toggles it every cycle.
  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int mode, input int budget,
                         output int doneAt, output int doneCount, output int lowCycles,
                         output int stallErr, output int lastX, output int lastY,
                         output int readyAfter);
    logic  prevHold;
    frag_t prevFrag;
    frag_t cur;
    got.delete();
    doneAt = -1; doneCount = 0; lowCycles = 0; stallErr = 0;
    lastX = -1; lastY = -1; readyAfter = -1;
    prevHold = 1'b0;
    prevFrag = '0;
    @(negedge clk);
    bus.tri_ax = 10'(ax); bus.tri_ay = 10'(ay);
    bus.tri_bx = 10'(bx); bus.tri_by = 10'(by);
    bus.tri_cx = 10'(cx); bus.tri_cy = 10'(cy);
    bus.tri_bz = 7'd127;  bus.tri_cz = 7'd127;
    bus.tri_valid  = 1'b1;
    bus.frag_ready = (mode == 0);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) bus.tri_valid = 1'b0;
      if (mode == 1) bus.frag_ready = k[0];
      cur = {bus.frag_x, bus.frag_y, bus.frag_uw, bus.frag_vw, bus.frag_ww, bus.frag_aw};
      if (prevHold && (!bus.frag_valid || cur !== prevFrag)) stallErr++;
      if (bus.frag_valid && bus.frag_ready) got.push_back(cur);
      prevHold = bus.frag_valid && !bus.frag_ready;
      prevFrag = cur;
      if (!bus.tri_ready) lowCycles++;
      if (bus.done) begin
        doneCount++;
        if (doneAt < 0) begin
          doneAt = k;
          lastX  = int'(bus.ras_x);
          lastY  = int'(bus.ras_y);
        end
      end
      if (doneAt >= 0 && k == doneAt + 1) begin
        readyAfter = int'(bus.tri_ready);
        break;
      end
    end
    bus.frag_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tri_valid = 1'b0;
    bus.frag_ready = 1'b1;
    bus.tri_ax = '0; bus.tri_ay = '0; bus.tri_bx = '0;
    bus.tri_by = '0; bus.tri_cx = '0; bus.tri_cy = '0;
    bus.tri_bz = '0; bus.tri_cz = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.tri_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_tri_ready got %b want 1", bus.tri_ready);
    end
    total++;
    if (bus.frag_valid !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_valid_done got %b/%b want 0/0", bus.frag_valid, bus.done);
    end
    total++;
    if (bus.ras_x !== 10'd0 || bus.ras_y !== 10'd0 || bus.ras_ax !== 10'd0 || bus.frag_x !== 10'd0) begin
      bad++; $display("[TB] FAIL reset_regs got ras_x=%0d ras_y=%0d ras_ax=%0d frag_x=%0d want 0",
                      bus.ras_x, bus.ras_y, bus.ras_ax, bus.frag_x);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.tri_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL post_reset_ready got %b want 1", bus.tri_ready);
    end
  endtask

  task automatic test_basic();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    bit ok;
    build_gold(10, 10, 13, 10, 10, 13);
    run_tri(10, 10, 13, 10, 10, 13, 0, 60, dAt, dCnt, low, sErr, lx, ly, rdy);
    total++;
    if (dAt !== 18) begin
      bad++; $display("[TB] FAIL basic_done_cycle got %0d want 18", dAt);
    end
    total++;
    if (dCnt !== 1 || rdy !== 1) begin
      bad++; $display("[TB] FAIL basic_done_pulse got count=%0d ready_after=%0d want 1/1", dCnt, rdy);
    end
    total++;
    if (low !== 18) begin
      bad++; $display("[TB] FAIL basic_busy_cycles got %0d want 18", low);
    end
    total++;
    if (got.size() !== 10) begin
      bad++; $display("[TB] FAIL basic_frag_count got %0d want 10", got.size());
    end
    total++;
    if (got.size() < 2 || got[0].x !== 10'd10 || got[0].y !== 10'd10 ||
        got[1].x !== 10'd11 || got[1].y !== 10'd10) begin
      bad++; $display("[TB] FAIL basic_first_frags got size %0d want (10,10),(11,10) first", got.size());
    end
    ok = (got.size() == gold.size());
    if (ok) foreach (got[i]) if (got[i] !== gold[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL basic_sequence got %0d frags want %0d golden", got.size(), gold.size());
    end
    total++;
    if (bus.ras_ax !== 10'd10 || bus.ras_bx !== 10'd13 || bus.ras_cy !== 10'd13 ||
        bus.ras_bz !== 7'd127 || bus.ras_cz !== 7'd127) begin
      bad++; $display("[TB] FAIL basic_latched got ax=%0d bx=%0d cy=%0d bz=%0d cz=%0d want 10/13/13/127/127",
                      bus.ras_ax, bus.ras_bx, bus.ras_cy, bus.ras_bz, bus.ras_cz);
    end
  endtask

  task automatic test_backpressure();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    bit ok;
    build_gold(10, 10, 13, 10, 10, 13);
    run_tri(10, 10, 13, 10, 10, 13, 1, 80, dAt, dCnt, low, sErr, lx, ly, rdy);
    ok = (got.size() == gold.size());
    if (ok) foreach (got[i]) if (got[i] !== gold[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL bp_sequence got %0d frags want %0d golden", got.size(), gold.size());
    end
    total++;
    if (sErr !== 0) begin
      bad++; $display("[TB] FAIL bp_stable got %0d unstable stall cycles want 0", sErr);
    end
    total++;
    if (dCnt !== 1 || dAt < 18) begin
      bad++; $display("[TB] FAIL bp_done got count=%0d cycle=%0d want 1 pulse at >=18", dCnt, dAt);
    end
  endtask

  task automatic test_empty_box();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    run_tri(700, 10, 800, 10, 700, 50, 0, 20, dAt, dCnt, low, sErr, lx, ly, rdy);
    total++;
    if (dAt !== 2 || dCnt !== 1) begin
      bad++; $display("[TB] FAIL empty_done got cycle=%0d count=%0d want 2/1", dAt, dCnt);
    end
    total++;
    if (got.size() !== 0) begin
      bad++; $display("[TB] FAIL empty_frags got %0d want 0", got.size());
    end
  endtask

  task automatic test_clip_edge();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    bit ok;
    build_gold(630, 470, 1000, 470, 630, 900);
    run_tri(630, 470, 1000, 470, 630, 900, 0, 200, dAt, dCnt, low, sErr, lx, ly, rdy);
    total++;
    if (lx !== 639 || ly !== 479) begin
      bad++; $display("[TB] FAIL clip_last_pixel got (%0d,%0d) want (639,479)", lx, ly);
    end
    total++;
    if (dAt !== 103) begin
      bad++; $display("[TB] FAIL clip_done_cycle got %0d want 103", dAt);
    end
    total++;
    if (got.size() !== 100) begin
      bad++; $display("[TB] FAIL clip_frag_count got %0d want 100", got.size());
    end
    ok = (got.size() == gold.size());
    if (ok) foreach (got[i]) if (got[i] !== gold[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL clip_sequence got %0d frags want %0d golden", got.size(), gold.size());
    end
  endtask

  task automatic test_degenerate();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    run_tri(5, 5, 10, 10, 15, 15, 0, 200, dAt, dCnt, low, sErr, lx, ly, rdy);
    total++;
    if (dAt !== 123) begin
      bad++; $display("[TB] FAIL degen_done_cycle got %0d want 123", dAt);
    end
    total++;
    if (got.size() !== 0 || lx !== 15 || ly !== 15) begin
      bad++; $display("[TB] FAIL degen_scan got frags=%0d last=(%0d,%0d) want 0 at (15,15)",
                      got.size(), lx, ly);
    end
  endtask

  task automatic test_reset_midscan();
    int dAt, dCnt, low, sErr, lx, ly, rdy;
    int seenDone;
    bit hit;
    @(negedge clk);
    bus.tri_ax = 10'd10; bus.tri_ay = 10'd10;
    bus.tri_bx = 10'd13; bus.tri_by = 10'd10;
    bus.tri_cx = 10'd10; bus.tri_cy = 10'd13;
    bus.tri_valid  = 1'b1;
    bus.frag_ready = 1'b0;
    hit = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.tri_valid = 1'b0;
      if (bus.frag_valid) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++; $display("[TB] FAIL midscan_frag_pending got frag_valid=0 want 1 within 40 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.frag_valid !== 1'b0 || bus.tri_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midscan_abort got frag_valid=%b tri_ready=%b want 0/1",
                      bus.frag_valid, bus.tri_ready);
    end
    seenDone = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seenDone++;
    end
    rst_n = 1'b1;
    bus.frag_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seenDone++;
    end
    total++;
    if (seenDone !== 0) begin
      bad++; $display("[TB] FAIL midscan_no_done got %0d pulses want 0", seenDone);
    end
    run_tri(10, 10, 13, 10, 10, 13, 0, 60, dAt, dCnt, low, sErr, lx, ly, rdy);
    total++;
    if (dAt !== 18 || got.size() !== 10) begin
      bad++; $display("[TB] FAIL midscan_rerun got done=%0d frags=%0d want 18/10", dAt, got.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_box();
    test_clip_edge();
    test_degenerate();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
